// File: rtl/rv_iopmp_dl_seq.sv
// Sequential IOPMP decision logic: scans the priority-ordered entry table ENTRIES_PER_CYCLE entries per cycle.
// Optional sticky error capture is enabled with `define RV_IOPMP_DL_ERR_CAPTURE_EN.
package rv_iopmp_pkg;
  typedef enum logic [1:0] {ACCESS_READ = 2'd0, ACCESS_WRITE = 2'd1, ACCESS_EXEC = 2'd2} access_t;
  typedef struct packed { logic [15:0] md; } srcmd_entry_t;
  typedef struct packed { logic [15:0] t; } mdcfg_entry_t;
  typedef struct packed { logic [31:0] addr; logic [1:0] mode; logic x; logic w; logic r; } entry_t;
endpackage

module rv_iopmp_dl_seq #(
  parameter int SID_WIDTH         = 8,
  parameter int NUMBER_MDS        = 2,
  parameter int NUMBER_ENTRIES    = 8,
  parameter int NUMBER_MASTERS    = 2,
  parameter int ENTRIES_PER_CYCLE = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [SID_WIDTH-1:0]          sid_i,
  input  rv_iopmp_pkg::access_t         access_type_i,
  input  logic [NUMBER_ENTRIES-1:0]     entry_match_i,
  input  logic [NUMBER_ENTRIES-1:0]     entry_allow_i,
  input  rv_iopmp_pkg::srcmd_entry_t    srcmd_table_i [NUMBER_MASTERS],
  input  rv_iopmp_pkg::mdcfg_entry_t    mdcfg_table_i [NUMBER_MDS],
  input  rv_iopmp_pkg::entry_t          entry_table_i [NUMBER_ENTRIES],
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic                          allow_transaction_o,
  output logic                          err_transaction_o,
  output logic [2:0]                    err_type_o,
  output logic [15:0]                   err_entry_index_o,
  output logic                          busy_o
`ifdef RV_IOPMP_DL_ERR_CAPTURE_EN
  ,
  output logic                          err_valid_o,
  input  logic                          err_clear_i,
  output logic [2:0]                    err_cap_type_o,
  output logic [15:0]                   err_cap_index_o
`endif
);
  localparam int  NC      = NUMBER_ENTRIES / ENTRIES_PER_CYCLE;
  localparam int  KW      = (NC > 1) ? $clog2(NC) : 1;
  localparam int  IW      = (NUMBER_ENTRIES > 1) ? $clog2(NUMBER_ENTRIES) : 1;
  localparam int  MW      = (NUMBER_MASTERS > 1) ? $clog2(NUMBER_MASTERS) : 1;
  localparam bit  SE_MODE = (NUMBER_MASTERS == 1);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t                      state;
  logic [KW-1:0]               k_q;
  logic                        fin_q;
  logic [SID_WIDTH-1:0]        sid_q;
  rv_iopmp_pkg::access_t       acc_q;
  logic [NUMBER_ENTRIES-1:0]   match_q;
  logic [NUMBER_ENTRIES-1:0]   allow_q;
  logic                        res_allow;
  logic [2:0]                  res_type;
  logic [15:0]                 res_index;

  logic [NUMBER_MDS-1:0]       sid_mds;
  logic [15:0]                 bound [NUMBER_MDS+1];
  logic [NUMBER_ENTRIES-1:0]   eligible;
  logic                        hit;
  logic [IW-1:0]               win;
  logic [2:0]                  deny_code;
  logic                        unused_fold;

  always_comb begin
    sid_mds = '0;
    if (!SE_MODE) sid_mds = srcmd_table_i[sid_q[MW-1:0]].md[NUMBER_MDS-1:0];
    bound[0] = '0;
    for (int m = 0; m < NUMBER_MDS; m++) bound[m+1] = mdcfg_table_i[m].t;
  end

  // MD m owns entries in [mdcfg[m-1].t, mdcfg[m].t); SE mode ignores ownership.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUMBER_ENTRIES; i++) begin
      logic in_dom;
      in_dom = SE_MODE;
      for (int m = 0; m < NUMBER_MDS; m++)
        if (sid_mds[m] && (16'(i) >= bound[m]) && (16'(i) < bound[m+1])) in_dom = 1'b1;
      eligible[i] = match_q[i] && in_dom;
    end
  end

  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int j = ENTRIES_PER_CYCLE - 1; j >= 0; j--) begin
      int idx;
      idx = int'(k_q) * ENTRIES_PER_CYCLE + j;
      if (idx < NUMBER_ENTRIES && eligible[idx]) begin
        hit = 1'b1;
        win = IW'(idx);
      end
    end
  end

  always_comb begin
    case (acc_q)
      rv_iopmp_pkg::ACCESS_WRITE: deny_code = 3'h2;
      rv_iopmp_pkg::ACCESS_EXEC:  deny_code = 3'h3;
      default:                    deny_code = 3'h1;
    endcase
  end

  always_comb begin
    unused_fold = ^sid_q;
    for (int i = 0; i < NUMBER_MASTERS; i++) unused_fold = unused_fold ^ (^srcmd_table_i[i]);
    for (int i = 0; i < NUMBER_ENTRIES; i++) unused_fold = unused_fold ^ (^entry_table_i[i]);
  end

  // fin_q marks a decided verdict; the following SCAN cycle hands it over to RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      k_q       <= '0;
      fin_q     <= 1'b0;
      sid_q     <= '0;
      acc_q     <= rv_iopmp_pkg::ACCESS_READ;
      match_q   <= '0;
      allow_q   <= '0;
      res_allow <= 1'b0;
      res_type  <= '0;
      res_index <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          sid_q     <= sid_i;
          acc_q     <= access_type_i;
          match_q   <= entry_match_i;
          allow_q   <= entry_allow_i;
          k_q       <= '0;
          state     <= SCAN;
          fin_q     <= 1'b0;
          res_allow <= 1'b0;
          res_type  <= '0;
          res_index <= '0;
          if (!enable_i) begin
            fin_q     <= 1'b1;
            res_allow <= 1'b1;
          end else if (!SE_MODE && (sid_i >= SID_WIDTH'(NUMBER_MASTERS))) begin
            fin_q    <= 1'b1;
            res_type <= 3'h6;
          end
        end
        SCAN: begin
          if (fin_q) begin
            state <= RESP;
          end else if (hit) begin
            fin_q <= 1'b1;
            if (allow_q[win]) begin
              res_allow <= 1'b1;
            end else begin
              res_type  <= deny_code;
              res_index <= 16'(win);
            end
          end else if (k_q == KW'(NC - 1)) begin
            fin_q    <= 1'b1;
            res_type <= 3'h5;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        RESP: if (rsp_ready_i) begin
          state     <= IDLE;
          fin_q     <= 1'b0;
          res_allow <= 1'b0;
          res_type  <= '0;
          res_index <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o         = (state == IDLE) && !rst_i;
  assign busy_o              = (state != IDLE);
  assign rsp_valid_o         = (state == RESP);
  assign allow_transaction_o = rsp_valid_o && res_allow;
  assign err_transaction_o   = rsp_valid_o && !res_allow;
  assign err_type_o          = rsp_valid_o ? res_type : 3'h0;
  assign err_entry_index_o   = rsp_valid_o ? res_index : 16'h0;

`ifdef RV_IOPMP_DL_ERR_CAPTURE_EN
  logic deny_hs;
  assign deny_hs = rsp_valid_o && rsp_ready_i && !res_allow;

  // Capture happens on the denied response handshake; a coincident clear yields to the new error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_o     <= 1'b0;
      err_cap_type_o  <= '0;
      err_cap_index_o <= '0;
    end else if (deny_hs && (!err_valid_o || err_clear_i)) begin
      err_valid_o     <= 1'b1;
      err_cap_type_o  <= res_type;
      err_cap_index_o <= res_index;
    end else if (err_clear_i) begin
      err_valid_o     <= 1'b0;
      err_cap_type_o  <= '0;
      err_cap_index_o <= '0;
    end
  end
`endif
endmodule

// File: tb/tb_rv_iopmp_dl_seq.sv
// Bench for rv_iopmp_dl_seq: directed plan cases plus randomized transactions against a first-match model.
module tb_rv_iopmp_dl_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [7:0] sid = '0;
  rv_iopmp_pkg::access_t access = rv_iopmp_pkg::ACCESS_READ;
  logic [7:0] match = '0;
  logic [7:0] allow = '0;
  rv_iopmp_pkg::srcmd_entry_t srcmd_tab [2];
  rv_iopmp_pkg::mdcfg_entry_t mdcfg_tab [2];
  rv_iopmp_pkg::entry_t       entry_tab [8];
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic allow_o, err_o, busy;
  logic [2:0] type_o;
  logic [15:0] index_o;
  logic err_clear = 1'b0;
`ifdef RV_IOPMP_DL_ERR_CAPTURE_EN
  logic err_valid;
  logic [2:0] cap_type;
  logic [15:0] cap_index;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rv_iopmp_dl_seq dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .sid_i(sid), .access_type_i(access),
    .entry_match_i(match), .entry_allow_i(allow),
    .srcmd_table_i(srcmd_tab), .mdcfg_table_i(mdcfg_tab), .entry_table_i(entry_tab),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .allow_transaction_o(allow_o), .err_transaction_o(err_o),
    .err_type_o(type_o), .err_entry_index_o(index_o), .busy_o(busy)
`ifdef RV_IOPMP_DL_ERR_CAPTURE_EN
    , .err_valid_o(err_valid), .err_clear_i(err_clear),
    .err_cap_type_o(cap_type), .err_cap_index_o(cap_index)
`endif
  );

  // Reference: first matching entry owned by one of the SID's MDs, in index order.
  task automatic model(output int lat, output logic a, output logic [2:0] t, output logic [15:0] ix);
    logic owned;
    int t0, t1;
    a = 1'b0; t = 3'h0; ix = 16'h0; lat = 5;
    t0 = int'(mdcfg_tab[0].t);
    t1 = int'(mdcfg_tab[1].t);
    if (!enable) begin a = 1'b1; lat = 1; return; end
    if (sid >= 8'd2) begin t = 3'h6; lat = 1; return; end
    for (int i = 0; i < 8; i++) begin
      owned = (srcmd_tab[sid[0]].md[0] && i < t0) ||
              (srcmd_tab[sid[0]].md[1] && i >= t0 && i < t1);
      if (match[i] && owned) begin
        if (allow[i]) a = 1'b1;
        else begin t = 3'(int'(access) + 1); ix = 16'(i); end
        lat = i / 2 + 2;
        return;
      end
    end
    t = 3'h5;
    lat = 5;
  endtask

  // Issues one request and completes the response handshake; lat counts edges after the accept edge.
  task automatic run_txn(input logic clr, output int lat, output logic a, output logic e,
                         output logic [2:0] t, output logic [15:0] ix);
    @(negedge clk);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    a = allow_o; e = err_o; t = type_o; ix = index_o;
    rsp_ready = 1'b1;
    err_clear = clr;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    err_clear = 1'b0;
  endtask

  task automatic set_tables(input logic [1:0] md0, input logic [1:0] md1);
    srcmd_tab[0].md = {14'h0, md0};
    srcmd_tab[1].md = {14'h0, md1};
    mdcfg_tab[0].t = 16'd4;
    mdcfg_tab[1].t = 16'd8;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || allow_o !== 1'b0 ||
        err_o !== 1'b0 || type_o !== 3'h0 || index_o !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b allow=%b err=%b type=%h idx=%h, required all 0",
               req_ready, rsp_valid, busy, allow_o, err_o, type_o, index_o);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b busy=%b, required rdy=1 busy=0", req_ready, busy);
    end
  endtask

  task automatic test_directed;
    int lat; logic a, e; logic [2:0] t; logic [15:0] ix;
    set_tables(2'b01, 2'b10);
    enable = 1'b1; sid = 8'd1; access = rv_iopmp_pkg::ACCESS_READ; match = 8'h30; allow = 8'h10;
    run_txn(1'b0, lat, a, e, t, ix);
    n_checks++;
    if (lat !== 4 || a !== 1'b1 || e !== 1'b0 || t !== 3'h0 || ix !== 16'h0) begin
      n_fail++;
      $display("FAIL hit_allow: lat=%0d a=%b e=%b t=%h ix=%0d, required lat=4 a=1 e=0 t=0 ix=0", lat, a, e, t, ix);
    end
    access = rv_iopmp_pkg::ACCESS_WRITE; allow = 8'h00;
    run_txn(1'b0, lat, a, e, t, ix);
    n_checks++;
    if (lat !== 4 || a !== 1'b0 || e !== 1'b1 || t !== 3'h2 || ix !== 16'd4) begin
      n_fail++;
      $display("FAIL hit_deny_write: lat=%0d a=%b e=%b t=%h ix=%0d, required lat=4 a=0 e=1 t=2 ix=4", lat, a, e, t, ix);
    end
    sid = 8'd0; access = rv_iopmp_pkg::ACCESS_READ; match = 8'h80; allow = 8'hff;
    run_txn(1'b0, lat, a, e, t, ix);
    n_checks++;
    if (lat !== 5 || a !== 1'b0 || e !== 1'b1 || t !== 3'h5 || ix !== 16'h0) begin
      n_fail++;
      $display("FAIL no_hit: lat=%0d a=%b e=%b t=%h ix=%0d, required lat=5 a=0 e=1 t=5 ix=0", lat, a, e, t, ix);
    end
    sid = 8'd3; match = 8'h01;
    run_txn(1'b0, lat, a, e, t, ix);
    n_checks++;
    if (lat !== 1 || a !== 1'b0 || e !== 1'b1 || t !== 3'h6 || ix !== 16'h0) begin
      n_fail++;
      $display("FAIL bad_sid: lat=%0d a=%b e=%b t=%h ix=%0d, required lat=1 a=0 e=1 t=6 ix=0", lat, a, e, t, ix);
    end
    enable = 1'b0; sid = 8'd200;
    run_txn(1'b0, lat, a, e, t, ix);
    n_checks++;
    if (lat !== 1 || a !== 1'b1 || e !== 1'b0 || t !== 3'h0 || ix !== 16'h0) begin
      n_fail++;
      $display("FAIL disabled: lat=%0d a=%b e=%b t=%h ix=%0d, required lat=1 a=1 e=0 t=0 ix=0", lat, a, e, t, ix);
    end
    enable = 1'b1;
  endtask

  task automatic test_backpressure;
    int waited;
    set_tables(2'b01, 2'b10);
    sid = 8'd1; access = rv_iopmp_pkg::ACCESS_WRITE; match = 8'h30; allow = 8'h00;
    @(negedge clk);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    waited = 0;
    while (!rsp_valid && waited < 40) begin @(posedge clk); #1; waited++; end
    n_checks++;
    if (waited !== 4) begin
      n_fail++;
      $display("FAIL bp_latency: lat=%0d, required 4", waited);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || err_o !== 1'b1 || type_o !== 3'h2 || index_o !== 16'd4 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: vld=%b err=%b t=%h ix=%0d rdy=%b, required vld=1 err=1 t=2 ix=4 rdy=0",
                 c, rsp_valid, err_o, type_o, index_o, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || type_o !== 3'h0 || index_o !== 16'h0) begin
      n_fail++;
      $display("FAIL bp_release: vld=%b rdy=%b t=%h ix=%0d, required vld=0 rdy=1 t=0 ix=0",
               rsp_valid, req_ready, type_o, index_o);
    end
  endtask

  task automatic test_reset_mid_scan;
    int seen;
    set_tables(2'b01, 2'b10);
    sid = 8'd0; access = rv_iopmp_pkg::ACCESS_READ; match = 8'h80; allow = 8'h00;
    @(negedge clk);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL scan_busy: busy=%b, required 1", busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b vld=%b rdy=%b, required busy=0 vld=0 rdy=0", busy, rsp_valid, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid || !req_ready) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL dropped_txn: %0d cycles with response or not ready, required 0", seen);
    end
  endtask

  task automatic test_random;
    int lat, elat; logic a, e, ea; logic [2:0] t, et; logic [15:0] ix, eix;
    int t0;
    for (int n = 0; n < 60; n++) begin
      enable = ($urandom_range(0, 7) != 0);
      sid = 8'($urandom_range(0, 3));
      access = rv_iopmp_pkg::access_t'(2'($urandom_range(0, 2)));
      match = 8'($urandom);
      allow = 8'($urandom);
      srcmd_tab[0].md = 16'($urandom_range(0, 3));
      srcmd_tab[1].md = 16'($urandom_range(0, 3));
      t0 = $urandom_range(0, 8);
      mdcfg_tab[0].t = 16'(t0);
      mdcfg_tab[1].t = 16'($urandom_range(t0, 8));
      model(elat, ea, et, eix);
      run_txn(1'b0, lat, a, e, t, ix);
      n_checks++;
      if (lat !== elat || a !== ea || e !== !ea || t !== et || ix !== eix) begin
        n_fail++;
        $display("FAIL random[%0d]: lat=%0d a=%b e=%b t=%h ix=%0d, required lat=%0d a=%b e=%b t=%h ix=%0d",
                 n, lat, a, e, t, ix, elat, ea, !ea, et, eix);
      end
    end
  endtask

`ifdef RV_IOPMP_DL_ERR_CAPTURE_EN
  task automatic test_err_capture;
    int lat; logic a, e; logic [2:0] t; logic [15:0] ix;
    @(negedge clk);
    err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    n_checks++;
    if (err_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cap_clear: valid=%b, required 0", err_valid);
    end
    set_tables(2'b01, 2'b10);
    enable = 1'b1; sid = 8'd1; access = rv_iopmp_pkg::ACCESS_WRITE; match = 8'h30; allow = 8'h00;
    run_txn(1'b0, lat, a, e, t, ix);
    access = rv_iopmp_pkg::ACCESS_READ; match = 8'h40;
    run_txn(1'b0, lat, a, e, t, ix);
    n_checks++;
    if (err_valid !== 1'b1 || cap_type !== 3'h2 || cap_index !== 16'd4) begin
      n_fail++;
      $display("FAIL cap_first: valid=%b t=%h ix=%0d, required valid=1 t=2 ix=4", err_valid, cap_type, cap_index);
    end
    sid = 8'd0; access = rv_iopmp_pkg::ACCESS_EXEC; match = 8'h04;
    run_txn(1'b1, lat, a, e, t, ix);
    n_checks++;
    if (err_valid !== 1'b1 || cap_type !== 3'h3 || cap_index !== 16'd2) begin
      n_fail++;
      $display("FAIL cap_clear_new: valid=%b t=%h ix=%0d, required valid=1 t=3 ix=2", err_valid, cap_type, cap_index);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) entry_tab[i] = '0;
    set_tables(2'b01, 2'b10);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_scan();
    test_random();
`ifdef RV_IOPMP_DL_ERR_CAPTURE_EN
    test_err_capture();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
